// File: rtl/cmp_sort_if.sv
// cmp_sort_if: handshake and bus bundle for cmp_sort_ctrl.
//   master : word source / consumer side (drives start, din, din_valid, dout_ready)
//   slave  : sorter side (drives busy, dout, dout_valid, done, swap_cnt)
interface cmp_sort_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             busy;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             done;
  logic [7:0]       swap_cnt;

  modport master (
    output start, din, din_valid, dout_ready,
    input  busy, dout, dout_valid, done, swap_cnt
  );

  modport slave (
    input  start, din, din_valid, dout_ready,
    output busy, dout, dout_valid, done, swap_cnt
  );
endinterface

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads a block of DEPTH unsigned words, bubble-sorts them in place
// with one shared comparator (early exit on a swap-free pass), then streams them out
// in ascending order over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cmp_sort_if.slave (start/din/din_valid in; busy/dout/dout_valid/done/swap_cnt out;
//              dout_ready in)
module cmp_sort_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  cmp_sort_if.slave  bus
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  logic [IW-1:0]    rd_idx_q, rd_idx_d;
  logic [IW-1:0]    i_q, i_d;
  logic [IW-1:0]    pass_len_q, pass_len_d;
  logic             swapped_q, swapped_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             done_q, done_d;
  logic [CW-1:0]    swap_cnt_q, swap_cnt_d;
  logic             do_swap_c;

  // Shared comparator: strictly greater, so equal words keep their order
  assign do_swap_c = (mem_q[i_q] > mem_q[i_q + IW'(1)]);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      i_q          <= '0;
      pass_len_q   <= '0;
      swapped_q    <= 1'b0;
      busy_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      swap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      i_q          <= i_d;
      pass_len_q   <= pass_len_d;
      swapped_q    <= swapped_d;
      busy_q       <= busy_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
      swap_cnt_q   <= swap_cnt_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    i_d          = i_q;
    pass_len_d   = pass_len_q;
    swapped_d    = swapped_q;
    busy_d       = busy_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    swap_cnt_d   = swap_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD;
          wr_idx_d   = '0;
          swap_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.din_valid) begin
          mem_d[wr_idx_q] = bus.din;
          if (wr_idx_q == IW'(DEPTH - 1)) begin
            state_d    = S_SORT;
            i_d        = '0;
            pass_len_d = IW'(DEPTH - 1);
            swapped_d  = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + IW'(1);
          end
        end
      end
      S_SORT: begin
        if (do_swap_c) begin
          mem_d[i_q]          = mem_q[i_q + IW'(1)];
          mem_d[i_q + IW'(1)] = mem_q[i_q];
          swapped_d           = 1'b1;
          if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + CW'(1);
        end
        if (i_q == pass_len_q - IW'(1)) begin
          if (!(swapped_q || do_swap_c) || (pass_len_q == IW'(1))) begin
            state_d      = S_OUTPUT;
            rd_idx_d     = '0;
            // First word must reflect a swap made on this very edge
            dout_d       = mem_d[0];
            dout_valid_d = 1'b1;
          end else begin
            pass_len_d = pass_len_q - IW'(1);
            i_d        = '0;
            swapped_d  = 1'b0;
          end
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_OUTPUT: begin
        if (bus.dout_ready) begin
          if (rd_idx_q == IW'(DEPTH - 1)) begin
            state_d      = S_IDLE;
            dout_valid_d = 1'b0;
            done_d       = 1'b1;
            busy_d       = 1'b0;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
            dout_d   = mem_q[rd_idx_q + IW'(1)];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.done       = done_q;
  assign bus.swap_cnt   = swap_cnt_q;
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: directed bench for cmp_sort_ctrl (WIDTH=4, DEPTH=4) with a
// scoreboard queue of expected sorted words filled at load time.
module tb_cmp_sort_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmp_sort_if #(.WIDTH(4)) bus ();

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_block();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("done_low_after_start", 32'(bus.done), 32'd0);
    check("swap_cnt_cleared", 32'(bus.swap_cnt), 32'd0);
  endtask

  // Loads four words; pushes the ascending order to the scoreboard and returns the
  // inversion count, which equals the number of adjacent swaps bubble sort needs.
  task automatic load(input int a, input int b, input int c, input int d,
                      input bit gapped, output int exp_swaps);
    int w[4];
    int s[4];
    int t;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    exp_swaps = 0;
    for (int x = 0; x < 4; x++)
      for (int y = x + 1; y < 4; y++)
        if (w[x] > w[y]) exp_swaps++;
    s = w;
    for (int x = 0; x < 4; x++)
      for (int y = x + 1; y < 4; y++)
        if (s[y] < s[x]) begin t = s[x]; s[x] = s[y]; s[y] = t; end
    for (int x = 0; x < 4; x++) sb.push_back(4'(s[x]));
    for (int k = 0; k < 4; k++) begin
      bus.din       = 4'(w[k]);
      bus.din_valid = 1'b1;
      tick();
      if (gapped && k < 3) begin
        bus.din_valid = 1'b0;
        bus.din       = 4'(k + 5);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
      end
    end
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_sort(input int exp_cycles, input bit stray);
    int n = 0;
    if (stray) bus.start = 1'b1;
    while (!bus.dout_valid && n < 100) begin
      check("busy_in_sort", 32'(bus.busy), 32'd1);
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("sort_cycles", 32'(n), 32'(exp_cycles));
  endtask

  task automatic drain(input int stall_at, input int exp_swaps, input logic [3:0] last);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    while (got < 4 && cyc < 100) begin
      bus.dout_ready = !(got == stall_at && stall < 5);
      check("dout_valid", 32'(bus.dout_valid), 32'd1);
      check("done_early", 32'(bus.done), 32'd0);
      if (!bus.dout_ready) begin
        check("hold_dout", 32'(bus.dout), 32'(sb[0]));
        stall++;
      end else begin
        check("dout_word", 32'(bus.dout), 32'(sb.pop_front()));
        got++;
      end
      tick();
      cyc++;
    end
    bus.dout_ready = 1'b0;
    check("words_out", 32'(got), 32'd4);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("valid_dropped", 32'(bus.dout_valid), 32'd0);
    check("busy_idle", 32'(bus.busy), 32'd0);
    check("dout_keeps_last", 32'(bus.dout), 32'(last));
    check("swap_cnt", 32'(bus.swap_cnt), 32'(exp_swaps));
  endtask

  initial begin
    int es;
    bus.start      = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_swap_cnt", 32'(bus.swap_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Reverse order: worst case
    start_block(); load(3, 2, 1, 0, 1'b0, es); wait_sort(6, 1'b0); drain(-1, es, 4'd3);
    // Pre-sorted: single pass, start coincides with previous done
    start_block(); load(1, 5, 9, 15, 1'b0, es); wait_sort(3, 1'b0); drain(-1, es, 4'd15);
    // Duplicates and extremes
    start_block(); load(15, 0, 15, 0, 1'b0, es); wait_sort(6, 1'b0); drain(-1, es, 4'd15);
    // Backpressure at rd_idx=1
    start_block(); load(7, 3, 11, 1, 1'b0, es); wait_sort(6, 1'b0); drain(1, es, 4'd11);

    // Asynchronous reset in the middle of a sort
    start_block(); load(3, 2, 1, 0, 1'b0, es);
    tick();
    tick();
    check("swap_cnt_midsort", 32'(bus.swap_cnt), 32'd2);
    #3 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_swap_cnt", 32'(bus.swap_cnt), 32'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    start_block(); load(2, 3, 0, 1, 1'b0, es); wait_sort(6, 1'b0); drain(-1, es, 4'd3);

    // Gapped load with stray starts during LOAD and SORT
    start_block(); load(9, 4, 12, 4, 1'b1, es); wait_sort(6, 1'b1); drain(-1, es, 4'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
